// File: rtl/mmio_io_ctrl.sv
// Memory-mapped I/O block: HEX/LEDR/LEDG output registers, debounced switches and
// pushbuttons, and a sticky key-press event/overrun register with write-1-to-clear.
module mmio_io_ctrl #(
  parameter int unsigned     DBITS           = 32,
  parameter int unsigned     DEBOUNCE_CYCLES = 50000,
  parameter logic [DBITS-1:0] ADDR_HEX   = DBITS'(32'hF0000000),
  parameter logic [DBITS-1:0] ADDR_LEDR  = DBITS'(32'hF0000004),
  parameter logic [DBITS-1:0] ADDR_LEDG  = DBITS'(32'hF0000008),
  parameter logic [DBITS-1:0] ADDR_KEY   = DBITS'(32'hF0000010),
  parameter logic [DBITS-1:0] ADDR_SW    = DBITS'(32'hF0000014),
  parameter logic [DBITS-1:0] ADDR_KEYEV = DBITS'(32'hF0000018)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] addr,
  input  logic             wrEn,
  input  logic [DBITS-1:0] wrData,
  output logic [DBITS-1:0] rdData,
  output logic             isIo,
  input  logic [9:0]       SW,
  input  logic [3:0]       KEY,
  output logic [9:0]       LEDR,
  output logic [7:0]       LEDG,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX3
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [15:0]   hex_reg;
  logic [9:0]    ledr_reg;
  logic [7:0]    ledg_reg;
  logic [CW-1:0] cnt;
  logic          tick;
  logic [9:0]    sw_s1, sw_s2, sw_samp, sw_deb;
  logic [3:0]    key_s1, key_s2, key_samp, key_deb, key_prev;
  logic [3:0]    press, ev_clr, ov_clr;
  logic [3:0]    ev, ov;
  logic          wr_hex, wr_ledr, wr_ledg, wr_keyev;
  logic          unused_ok;

  assign unused_ok = ^wrData[DBITS-1:16];

  assign wr_hex   = wrEn && (addr == ADDR_HEX);
  assign wr_ledr  = wrEn && (addr == ADDR_LEDR);
  assign wr_ledg  = wrEn && (addr == ADDR_LEDG);
  assign wr_keyev = wrEn && (addr == ADDR_KEYEV);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hex_reg  <= '0;
      ledr_reg <= '0;
      ledg_reg <= '0;
    end else begin
      if (wr_hex)  hex_reg  <= wrData[15:0];
      if (wr_ledr) ledr_reg <= wrData[9:0];
      if (wr_ledg) ledg_reg <= wrData[7:0];
    end
  end

  // Keys are inverted at the synchronizer input so every stage holds 1 = pressed
  // and the all-zero reset state reads as released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      key_s1 <= '0;
      key_s2 <= '0;
    end else begin
      sw_s1  <= SW;
      sw_s2  <= sw_s1;
      key_s1 <= ~KEY;
      key_s2 <= key_s1;
    end
  end

  assign tick = (cnt == CW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt <= '0;
    else        cnt <= tick ? '0 : cnt + 1'b1;
  end

  // A debounced bit only follows the input when this tick's sample agrees with the last one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_samp  <= '0;
      key_samp <= '0;
      sw_deb   <= '0;
      key_deb  <= '0;
    end else if (tick) begin
      sw_samp  <= sw_s2;
      key_samp <= key_s2;
      sw_deb   <= (sw_deb  & (sw_s2  ^ sw_samp))  | (sw_s2  & ~(sw_s2  ^ sw_samp));
      key_deb  <= (key_deb & (key_s2 ^ key_samp)) | (key_s2 & ~(key_s2 ^ key_samp));
    end
  end

  assign press  = key_deb & ~key_prev;
  assign ev_clr = wr_keyev ? wrData[3:0] : '0;
  assign ov_clr = wr_keyev ? wrData[7:4] : '0;

  // A press always sets its event; it only flags overrun when the event was
  // already pending and not being cleared in this same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_prev <= '0;
      ev       <= '0;
      ov       <= '0;
    end else begin
      key_prev <= key_deb;
      ev       <= (ev & ~ev_clr) | press;
      ov       <= (ov & ~ov_clr) | (press & ev & ~ev_clr);
    end
  end

  always_comb begin
    rdData = '0;
    isIo   = 1'b1;
    case (addr)
      ADDR_HEX:   rdData = DBITS'(hex_reg);
      ADDR_LEDR:  rdData = DBITS'(ledr_reg);
      ADDR_LEDG:  rdData = DBITS'(ledg_reg);
      ADDR_KEY:   rdData = DBITS'(key_deb);
      ADDR_SW:    rdData = DBITS'(sw_deb);
      ADDR_KEYEV: rdData = DBITS'({ov, ev});
      default:    isIo   = 1'b0;
    endcase
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign HEX0 = seg7(hex_reg[3:0]);
  assign HEX1 = seg7(hex_reg[7:4]);
  assign HEX2 = seg7(hex_reg[11:8]);
  assign HEX3 = seg7(hex_reg[15:12]);
  assign LEDR = ledr_reg;
  assign LEDG = ledg_reg;

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Directed bench for mmio_io_ctrl with a short debounce period.
module tb_mmio_io_ctrl;

  localparam logic [31:0] A_HEX   = 32'hF0000000;
  localparam logic [31:0] A_LEDR  = 32'hF0000004;
  localparam logic [31:0] A_LEDG  = 32'hF0000008;
  localparam logic [31:0] A_KEY   = 32'hF0000010;
  localparam logic [31:0] A_SW    = 32'hF0000014;
  localparam logic [31:0] A_KEYEV = 32'hF0000018;
  localparam logic [31:0] A_NONE  = 32'hF000000C;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        wrEn;
  logic [31:0] wrData;
  logic [31:0] rdData;
  logic        isIo;
  logic [9:0]  SW;
  logic [3:0]  KEY;
  logic [9:0]  LEDR;
  logic [7:0]  LEDG;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  mmio_io_ctrl #(.DBITS(32), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wrEn(wrEn), .wrData(wrData),
    .rdData(rdData), .isIo(isIo), .SW(SW), .KEY(KEY), .LEDR(LEDR), .LEDG(LEDG),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wrData = d; wrEn = 1'b1;
    @(negedge clk);
    wrEn = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1 check(tag, rdData, exp);
  endtask

  // Polls once per cycle; a timeout shows up as a failed comparison.
  task automatic wait_rd(input string tag, input logic [31:0] a, input logic [31:0] exp,
                         input int unsigned max_cyc);
    int unsigned n = 0;
    logic [31:0] got;
    addr = a;
    #1 got = rdData;
    while (got !== exp && n < max_cyc) begin
      @(negedge clk);
      addr = a;
      #1 got = rdData;
      n++;
    end
    check(tag, got, exp);
  endtask

  initial begin
    reset = 1'b0; addr = '0; wrEn = 1'b0; wrData = '0; SW = '0; KEY = 4'hF;
    repeat (2) @(negedge clk);
    #1;
    check("rst_hex0", 32'(HEX0), 32'h40);
    check("rst_hex3", 32'(HEX3), 32'h40);
    check("rst_ledr", 32'(LEDR), 32'h0);
    check("rst_keyev", rdData, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    wr(A_LEDR, 32'h155);
    wr(A_LEDG, 32'hA5);
    wr(A_HEX, 32'h0000BEEF);
    #1;
    check("hex3_b", 32'(HEX3), 32'h03);
    check("hex2_e", 32'(HEX2), 32'h06);
    check("hex1_e", 32'(HEX1), 32'h06);
    check("hex0_f", 32'(HEX0), 32'h0E);
    rd("rd_hex", A_HEX, 32'h0000BEEF);
    rd("rd_ledr", A_LEDR, 32'h155);
    rd("rd_ledg", A_LEDG, 32'hA5);
    check("ledr_out", 32'(LEDR), 32'h155);
    check("ledg_out", 32'(LEDG), 32'hA5);

    wr(A_SW, 32'h3FF);
    wr(A_KEY, 32'hF);
    wr(A_NONE, 32'hFFFF);
    rd("rd_sw_nowr", A_SW, 32'h0);
    rd("rd_key_nowr", A_KEY, 32'h0);
    rd("rd_unmapped", A_NONE, 32'h0);
    check("isio_unmapped", 32'(isIo), 32'h0);
    addr = A_KEYEV; #1 check("isio_keyev", 32'(isIo), 32'h1);
    rd("ledr_keep", A_LEDR, 32'h155);
    rd("hex_keep", A_HEX, 32'h0000BEEF);

    @(negedge clk);
    SW = 10'h2A0;
    wait_rd("sw_deb", A_SW, 32'h2A0, 11);
    repeat (3) @(negedge clk);
    SW = 10'h2A1;
    repeat (3) @(negedge clk);
    SW = 10'h2A0;
    repeat (14) @(negedge clk);
    rd("sw_glitch", A_SW, 32'h2A0);

    KEY = 4'b1011;
    wait_rd("key2_press", A_KEY, 32'h4, 11);
    wait_rd("key2_ev", A_KEYEV, 32'h04, 2);
    @(negedge clk);
    KEY = 4'hF;
    wait_rd("key2_rel", A_KEY, 32'h0, 11);
    repeat (2) @(negedge clk);
    rd("key2_rel_ev", A_KEYEV, 32'h04);
    KEY = 4'b1011;
    wait_rd("key2_press2", A_KEY, 32'h4, 11);
    wait_rd("key2_ovr", A_KEYEV, 32'h44, 2);
    @(negedge clk);
    KEY = 4'hF;
    wait_rd("key2_rel2", A_KEY, 32'h0, 11);
    wr(A_KEYEV, 32'h40);
    rd("w1c_ovr", A_KEYEV, 32'h04);
    wr(A_KEYEV, 32'h04);
    rd("w1c_ev", A_KEYEV, 32'h00);

    // KEY[1] press: the W1C is issued in the cycle the press is being detected.
    @(negedge clk);
    KEY = 4'b1101;
    wait_rd("key1_press", A_KEY, 32'h2, 11);
    addr = A_KEYEV; wrData = 32'h02; wrEn = 1'b1;
    @(negedge clk);
    wrEn = 1'b0;
    rd("set_wins", A_KEYEV, 32'h02);
    @(negedge clk);
    KEY = 4'hF;
    wait_rd("key1_rel", A_KEY, 32'h0, 11);

    wr(A_LEDR, 32'h3FF);
    #1 check("ledr_ff", 32'(LEDR), 32'h3FF);
    @(negedge clk);
    SW = 10'h155;
    repeat (4) @(negedge clk);
    addr = A_LEDG; wrData = 32'hFF; wrEn = 1'b1;
    #2 reset = 1'b0;
    #1 check("rst_ledr_now", 32'(LEDR), 32'h0);
    check("rst_hex0_now", 32'(HEX0), 32'h40);
    rd("rst_rd_hex", A_HEX, 32'h0);
    rd("rst_rd_ledr", A_LEDR, 32'h0);
    rd("rst_rd_ledg", A_LEDG, 32'h0);
    rd("rst_rd_sw", A_SW, 32'h0);
    rd("rst_rd_keyev", A_KEYEV, 32'h0);
    addr = A_LEDR; #1 check("rst_isio_ledr", 32'(isIo), 32'h1);
    addr = A_NONE; #1 check("rst_isio_none", 32'(isIo), 32'h0);
    @(negedge clk);
    wrEn = 1'b0;
    reset = 1'b1;
    rd("post_rst_ledg", A_LEDG, 32'h0);
    rd("post_rst_sw", A_SW, 32'h0);
    wait_rd("post_rst_sw_deb", A_SW, 32'h155, 11);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
